bp_be_dep_tracker: RTL and testbench
====================================

Name: bp_be_dep_tracker

Overview:
- Producer side of the dispatch hazard interface: records each dispatched instruction's writeback/class info and shifts it down a 5-entry status pipe (EX1, EX2, EX3/IWB, FWB, retire-shadow) in lockstep with the calculator.
- Emits the packed per-stage dependency vector and the memory-credit status (full/empty) that the dispatch hazard detector consumes.
- Sits in bp_be_checker beside the detector, fed by the issue/decode stage and by exception/kill and memory-response logic.

Parameters:
- stages_p, 5, number of tracked pipeline stages (fixed at 5; the value is checked, not generalised).
- credits_p, 4, maximum outstanding memory operations.
- reg_addr_width_p, 5, architectural register address width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- dispatch_v_i  in  1  instruction dispatched this cycle.
- rd_addr_i  in  5  destination register.
- irf_w_v_i  in  1  writes the integer register file.
- frf_w_v_i  in  1  writes the FP register file.
- pipe_sel_i  in  2  pipe class: 0 int, 1 mul, 2 mem, 3 fp.
- serial_v_i  in  1  serialising instruction (CSR, fence, xRET).
- kill_i  in  3  bit k squashes the entry currently in stage k (k = 0..2).
- flush_i  in  1  squash stages 0..2 and any same-cycle dispatch.
- credit_return_i  in  1  memory op completed; release one credit.
- dep_status_o  out  70  5 x 14-bit entries. Stage 0 occupies bits [13:0]. Per-entry layout, MSB to LSB: v, serial_v, mem_v, int_iwb_v, mul_iwb_v, mem_iwb_v, fp_iwb_v, mem_fwb_v, fp_fwb_v, rd_addr[4:0].
- credits_full_o  out  1  outstanding count == credits_p.
- credits_empty_o  out  1  outstanding count == 0.
- credit_err_o  out  1  sticky: a return was seen at zero, or a spend was seen at full.

Behaviour:
- Reset (asynchronous): all entries zero, credit count 0, credits_empty_o=1, credits_full_o=0, credit_err_o=0.
- Every cycle the pipe shifts unconditionally: entry[i+1] <= entry[i]; entry[4] is discarded.
- Stage 0 loads a new entry on dispatch_v_i & ~flush_i, otherwise zero. Outputs are registered, so a dispatch at edge t is visible in stage 0 after edge t.
- New-entry encoding:
  - v = 1; serial_v = serial_v_i; mem_v = (pipe_sel_i == 2).
  - Exactly one *_iwb_v bit is set, chosen by pipe_sel_i, and only if irf_w_v_i and rd_addr_i != 0.
  - mem_fwb_v / fp_fwb_v are set if frf_w_v_i and pipe_sel_i is 2 or 3 respectively. frf_w_v_i with pipe 0 or 1 sets no fwb bit.
  - rd_addr is stored verbatim, including x0.
- Kill: if kill_i[k] is set, the entry moving from stage k into stage k+1 is written as all zero (rd_addr included). kill_i has no effect on stages 3 and 4. An entry killed in stage 0 never reaches stage 1.
- flush_i acts as kill_i = 3'b111 plus suppression of the same-cycle dispatch.
- Credit counter, width clog2(credits_p+1):
  - Spend: an entry with v & mem_v leaves stage 1 into stage 2 without being killed (commit point).
  - Return: credit_return_i.
  - Spend and return in the same cycle: count unchanged. A return at count 0 is also permitted in that cycle.
  - A lone return at 0 is ignored and sets credit_err_o. A spend at credits_p saturates and sets credit_err_o.
  - credit_err_o clears only on reset.
- credits_full_o / credits_empty_o are decoded combinationally from the registered count.
- Reset asserted mid-operation clears everything immediately. First dispatch accepted after deassertion behaves normally.

Test Plan:
- Single dispatch, rd=7, irf_w, pipe=1 (mul) → stage 0 entry = {v=1, mul_iwb_v=1, rd=7}. It appears in stages 1, 2, 3, 4 on the next four cycles, and is all-zero at stage 4 afterwards.
- Dispatch with rd=0, irf_w, pipe=0 → v=1, all iwb bits 0, rd_addr=0. Same with frf_w, pipe=3, rd=0 → fp_fwb_v=1.
- Mem op dispatched, kill_i[1] asserted while it sits in stage 1 → stage 2 all-zero, credit count stays 0, credits_empty_o stays 1.
- Four uncommitted-free mem ops, no returns → credits_full_o=1 after the 4th reaches stage 2. A 5th → credit_err_o=1 and count stays 4. A return with a concurrent spend → count stays 4.
- flush_i together with dispatch_v_i while stages 0..2 are valid → stages 1..3 all zero next cycle and stage 0 zero. Stage 4 receives the old stage 3 unaffected.
- Async reset pulsed between clock edges with the pipe full and count=2 → all outputs return to reset values before the next edge. Dispatch after release → normal stage 0 entry.

Source files
------------

// File: rtl/bp_be_dep_tracker.sv
// Dispatch-side hazard status pipe: tracks writeback/class info of in-flight instructions
// across five stages and keeps the outstanding memory-credit count for the hazard detector.
module bp_be_dep_tracker #(
    parameter int unsigned stages_p         = 5,
    parameter int unsigned credits_p        = 4,
    parameter int unsigned reg_addr_width_p = 5
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      dispatch_v_i,
    input  logic [reg_addr_width_p-1:0]               rd_addr_i,
    input  logic                                      irf_w_v_i,
    input  logic                                      frf_w_v_i,
    input  logic [1:0]                                pipe_sel_i,
    input  logic                                      serial_v_i,
    input  logic [2:0]                                kill_i,
    input  logic                                      flush_i,
    input  logic                                      credit_return_i,
    output logic [stages_p*(9+reg_addr_width_p)-1:0]  dep_status_o,
    output logic                                      credits_full_o,
    output logic                                      credits_empty_o,
    output logic                                      credit_err_o
);

    localparam int unsigned EntryW = 9 + reg_addr_width_p;
    localparam int unsigned CntW   = $clog2(credits_p + 1);

    if (stages_p != 5) begin : g_bad_stages
        $error("bp_be_dep_tracker supports exactly 5 stages");
    end

    typedef struct packed {
        logic                        v;
        logic                        serial_v;
        logic                        mem_v;
        logic                        int_iwb_v;
        logic                        mul_iwb_v;
        logic                        mem_iwb_v;
        logic                        fp_iwb_v;
        logic                        mem_fwb_v;
        logic                        fp_fwb_v;
        logic [reg_addr_width_p-1:0] rd_addr;
    } entry_t;

    entry_t            new_entry;
    entry_t            stage_q [stages_p];
    entry_t            stage_d [stages_p];
    logic [3:0]        kill_vec;
    logic              spend;
    logic [CntW-1:0]   count_q, count_d;
    logic              err_q, err_d;

    // Flush behaves as killing stages 0..2; stages 3 and 4 are never killed.
    assign kill_vec = {1'b0, kill_i | {3{flush_i}}};

    always_comb begin
        new_entry = '0;
        if (dispatch_v_i && !flush_i) begin
            new_entry.v         = 1'b1;
            new_entry.serial_v  = serial_v_i;
            new_entry.mem_v     = (pipe_sel_i == 2'd2);
            new_entry.mem_fwb_v = frf_w_v_i && (pipe_sel_i == 2'd2);
            new_entry.fp_fwb_v  = frf_w_v_i && (pipe_sel_i == 2'd3);
            new_entry.rd_addr   = rd_addr_i;
            // Writes to x0 are architecturally dropped, so they carry no iwb hazard.
            if (irf_w_v_i && (rd_addr_i != '0)) begin
                unique case (pipe_sel_i)
                    2'd0: new_entry.int_iwb_v = 1'b1;
                    2'd1: new_entry.mul_iwb_v = 1'b1;
                    2'd2: new_entry.mem_iwb_v = 1'b1;
                    2'd3: new_entry.fp_iwb_v  = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        stage_d[0] = new_entry;
        for (int i = 1; i < stages_p; i++) begin
            stage_d[i] = kill_vec[i-1] ? '0 : stage_q[i-1];
        end
    end

    // A memory op commits, and consumes a credit, when it survives the move into stage 2.
    assign spend = stage_q[1].v && stage_q[1].mem_v && !kill_vec[1];

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (spend && !credit_return_i) begin
            if (count_q == CntW'(credits_p)) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (credit_return_i && !spend) begin
            if (count_q == '0) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < stages_p; i++) begin
                stage_q[i] <= '0;
            end
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < stages_p; i++) begin
                stage_q[i] <= stage_d[i];
            end
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        dep_status_o = '0;
        for (int i = 0; i < stages_p; i++) begin
            dep_status_o[i*EntryW +: EntryW] = stage_q[i];
        end
    end

    assign credits_full_o  = (count_q == CntW'(credits_p));
    assign credits_empty_o = (count_q == '0);
    assign credit_err_o    = err_q;

endmodule

// File: tb/tb_bp_be_dep_tracker.sv
// Directed bench for bp_be_dep_tracker: entry encoding, shifting, kill/flush, credits, reset.
module tb_bp_be_dep_tracker;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        dispatch_v_i;
    logic [4:0]  rd_addr_i;
    logic        irf_w_v_i;
    logic        frf_w_v_i;
    logic [1:0]  pipe_sel_i;
    logic        serial_v_i;
    logic [2:0]  kill_i;
    logic        flush_i;
    logic        credit_return_i;
    logic [69:0] dep_status_o;
    logic        credits_full_o;
    logic        credits_empty_o;
    logic        credit_err_o;

    int checks = 0;
    int errors = 0;

    bp_be_dep_tracker dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .dispatch_v_i    (dispatch_v_i),
        .rd_addr_i       (rd_addr_i),
        .irf_w_v_i       (irf_w_v_i),
        .frf_w_v_i       (frf_w_v_i),
        .pipe_sel_i      (pipe_sel_i),
        .serial_v_i      (serial_v_i),
        .kill_i          (kill_i),
        .flush_i         (flush_i),
        .credit_return_i (credit_return_i),
        .dep_status_o    (dep_status_o),
        .credits_full_o  (credits_full_o),
        .credits_empty_o (credits_empty_o),
        .credit_err_o    (credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic irf, input logic frf,
                         input logic [1:0] pipe, input logic serial);
        dispatch_v_i = v;
        rd_addr_i    = rd;
        irf_w_v_i    = irf;
        frf_w_v_i    = frf;
        pipe_sel_i   = pipe;
        serial_v_i   = serial;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        kill_i          = 3'b000;
        flush_i         = 1'b0;
        credit_return_i = 1'b0;
    endtask

    function automatic logic [13:0] stg(input int i);
        return dep_status_o[i*14 +: 14];
    endfunction

    initial begin
        reset_i = 1'b1;
        idle();
        step();
        step();
        check("reset_status", dep_status_o, 70'd0);
        check("reset_empty", 70'(credits_empty_o), 70'd1);
        check("reset_full", 70'(credits_full_o), 70'd0);
        check("reset_err", 70'(credit_err_o), 70'd0);
        reset_i = 1'b0;

        // Mul op, rd=7: v(13) | mul_iwb(9) | rd 7
        drive(1'b1, 5'd7, 1'b1, 1'b0, 2'd1, 1'b0);
        step();
        check("mul_stage0", 70'(stg(0)), 70'h2207);
        idle();
        for (int s = 1; s < 5; s++) begin
            step();
            check($sformatf("mul_stage%0d", s), 70'(stg(s)), 70'h2207);
        end
        step();
        check("mul_drained", dep_status_o, 70'd0);

        // x0 destination: no iwb bit, rd stored as 0
        drive(1'b1, 5'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        step();
        check("int_x0", 70'(stg(0)), 70'h2000);
        // FP op to f0 still sets fp_fwb(5); serial also recorded (12)
        drive(1'b1, 5'd0, 1'b0, 1'b1, 2'd3, 1'b1);
        step();
        check("fp_f0_serial", 70'(stg(0)), 70'h3020);
        // frf write on int pipe sets no fwb bit
        drive(1'b1, 5'd6, 1'b0, 1'b1, 2'd0, 1'b0);
        step();
        check("frf_int_pipe", 70'(stg(0)), 70'h2006);
        idle();
        step(); step(); step(); step(); step();

        // Mem op rd=5: v | mem_v(11) | mem_iwb(8) | 5, killed in stage 1
        drive(1'b1, 5'd5, 1'b1, 1'b0, 2'd2, 1'b0);
        step();
        check("mem_stage0", 70'(stg(0)), 70'h2905);
        idle();
        step();
        check("mem_stage1", 70'(stg(1)), 70'h2905);
        kill_i = 3'b010;
        step();
        kill_i = 3'b000;
        check("mem_killed_stage2", 70'(stg(2)), 70'h0);
        check("mem_killed_empty", 70'(credits_empty_o), 70'd1);
        step();
        check("mem_killed_empty2", 70'(credits_empty_o), 70'd1);

        // Four mem ops fill the credits
        drive(1'b1, 5'd1, 1'b0, 1'b0, 2'd2, 1'b0);
        step(); step(); step(); step();
        idle();
        step();
        check("three_spent_full", 70'(credits_full_o), 70'd0);
        check("three_spent_empty", 70'(credits_empty_o), 70'd0);
        step();
        check("four_spent_full", 70'(credits_full_o), 70'd1);
        check("four_spent_err", 70'(credit_err_o), 70'd0);

        // Fifth spend saturates and flags the error
        drive(1'b1, 5'd2, 1'b0, 1'b0, 2'd2, 1'b0);
        step();
        idle();
        step(); step();
        check("over_spend_err", 70'(credit_err_o), 70'd1);
        check("over_spend_full", 70'(credits_full_o), 70'd1);

        // Spend with concurrent return leaves count at 4
        drive(1'b1, 5'd3, 1'b0, 1'b0, 2'd2, 1'b0);
        step();
        idle();
        step();
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;
        check("spend_ret_full", 70'(credits_full_o), 70'd1);
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;
        check("ret_to3_full", 70'(credits_full_o), 70'd0);
        check("ret_to3_empty", 70'(credits_empty_o), 70'd0);
        credit_return_i = 1'b1;
        step(); step();
        check("ret_to1_empty", 70'(credits_empty_o), 70'd0);
        step();
        credit_return_i = 1'b0;
        check("ret_to0_empty", 70'(credits_empty_o), 70'd1);

        // Flush with dispatch: stages 0..3 cleared, old stage 3 reaches stage 4
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 5'(k), 1'b1, 1'b0, 2'd0, 1'b0);
            step();
        end
        check("pre_flush_s3", 70'(stg(3)), 70'h2401);
        drive(1'b1, 5'd5, 1'b1, 1'b0, 2'd0, 1'b0);
        flush_i = 1'b1;
        step();
        idle();
        check("flush_s4", 70'(stg(4)), 70'h2401);
        check("flush_s0_s3", 70'(dep_status_o[55:0]), 70'h0);

        // Fill: two mem ops then int ops, count reaches 2, pipe fully valid
        drive(1'b1, 5'd8, 1'b0, 1'b0, 2'd2, 1'b0);
        step(); step();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 2'd0, 1'b0);
        step(); step(); step();
        check("fill_empty", 70'(credits_empty_o), 70'd0);
        check("fill_s4", 70'(stg(4)), 70'h2808);
        check("fill_s0", 70'(stg(0)), 70'h2409);
        idle();
        #2 reset_i = 1'b1;
        #1;
        check("async_rst_status", dep_status_o, 70'd0);
        check("async_rst_empty", 70'(credits_empty_o), 70'd1);
        check("async_rst_err", 70'(credit_err_o), 70'd0);
        #1 reset_i = 1'b0;
        drive(1'b1, 5'd9, 1'b1, 1'b0, 2'd0, 1'b0);
        step();
        idle();
        check("post_rst_dispatch", dep_status_o, 70'h2409);

        // Lone return at zero is ignored but flagged
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;
        check("ret_at0_err", 70'(credit_err_o), 70'd1);
        check("ret_at0_empty", 70'(credits_empty_o), 70'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
